// File: rtl/kwta_pkg.sv
// Shared types and helpers for the k-winner-take-all stages of the temporal column.
package kwta_pkg;

  typedef enum logic {EDGE_RISING, EDGE_FALLING} edge_mode_e;
  typedef enum logic {TIE_FIXED, TIE_RR} tie_mode_e;

  function automatic int popcount(input logic [63:0] v);
    int n = 0;
    for (int i = 0; i < 64; i++) n += int'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/kwta_priority_sel.sv
// Grants the first 'limit' requests in rotating priority order starting at 'start';
// last_idx is the granted index that came last in that order.
module kwta_priority_sel #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1,
  parameter int LW = $clog2(N + 1)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [LW-1:0] limit,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] last_idx
);

  logic [N-1:0] rot;
  logic [N-1:0] sel;
  logic [N:0]   therm;

  always_comb begin
    int cnt;
    cnt      = 0;
    rot      = '0;
    sel      = '0;
    therm    = '0;
    grant    = '0;
    last_idx = '0;
    for (int c = 0; c <= N; c++) therm[c] = (c < int'(limit));
    for (int j = 0; j < N; j++) rot[j] = req[(int'(start) + j) % N];
    // therm indexed by the number of requests ahead of j keeps only the first 'limit'
    for (int j = 0; j < N; j++) begin
      sel[j] = rot[j] & therm[cnt];
      cnt += int'(rot[j]);
    end
    for (int j = 0; j < N; j++) begin
      if (sel[j]) begin
        grant[(int'(start) + j) % N] = 1'b1;
        last_idx = IW'((int'(start) + j) % N);
      end
    end
  end

endmodule

// File: rtl/kwta_tie_break.sv
// kWTA stage: passes the first K spike edges per gamma cycle as fixed-width pulses,
// with deterministic fixed or round-robin tie-breaking among simultaneous edges.
module kwta_tie_break
  import kwta_pkg::*;
#(
  parameter int         NUM_INPUTS        = 8,
  parameter int         K                 = 3,
  parameter int         GAMMA_CYCLE_WIDTH = 16,
  parameter int         PULSE_WIDTH       = 8,
  parameter edge_mode_e EDGE_MODE         = EDGE_RISING,
  parameter tie_mode_e  TIE_MODE          = TIE_FIXED,
  localparam int        CW                = $clog2(K + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_INPUTS-1:0] input_spikes,
  output logic [NUM_INPUTS-1:0] output_spikes,
  output logic                  gamma_start,
  output logic [CW-1:0]         win_count
);

  localparam int GW = (GAMMA_CYCLE_WIDTH > 1) ? $clog2(GAMMA_CYCLE_WIDTH) : 1;
  localparam int PW = $clog2(PULSE_WIDTH + 1);
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int LW = $clog2(NUM_INPUTS + 1);
  localparam logic [NUM_INPUTS-1:0] IDLE =
    (EDGE_MODE == EDGE_FALLING) ? {NUM_INPUTS{1'b1}} : {NUM_INPUTS{1'b0}};

  logic [GW-1:0]         gcnt;
  logic [NUM_INPUTS-1:0] prev;
  logic [NUM_INPUTS-1:0] won;
  logic [IW-1:0]         ptr;
  logic [PW-1:0]         pcnt [NUM_INPUTS];

  logic                  new_cycle;
  logic [NUM_INPUTS-1:0] edges;
  logic [NUM_INPUTS-1:0] won_eff;
  logic [NUM_INPUTS-1:0] eligible;
  logic [NUM_INPUTS-1:0] grant;
  logic [CW-1:0]         cnt_eff;
  logic [LW-1:0]         rem;
  logic [IW-1:0]         start;
  logic [IW-1:0]         last_idx;

  // XOR with the idle level maps both encodings onto active-high
  assign edges     = (input_spikes ^ IDLE) & ~(prev ^ IDLE);
  assign new_cycle = (gcnt == '0);
  assign won_eff   = new_cycle ? '0 : won;
  assign cnt_eff   = new_cycle ? '0 : win_count;
  assign eligible  = edges & ~won_eff;
  assign rem       = LW'(K) - LW'(cnt_eff);
  assign start     = (TIE_MODE == TIE_RR) ? ptr : '0;

  kwta_priority_sel #(.N(NUM_INPUTS), .IW(IW), .LW(LW)) u_sel (
    .req      (eligible),
    .start    (start),
    .limit    (rem),
    .grant    (grant),
    .last_idx (last_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gcnt      <= '0;
      prev      <= IDLE;
      won       <= '0;
      win_count <= '0;
      ptr       <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) pcnt[i] <= '0;
    end else begin
      gcnt      <= (gcnt == GW'(GAMMA_CYCLE_WIDTH - 1)) ? '0 : gcnt + 1'b1;
      prev      <= input_spikes;
      won       <= won_eff | grant;
      win_count <= cnt_eff + CW'(popcount(64'(grant)));
      if (TIE_MODE == TIE_RR && grant != '0)
        ptr <= (last_idx == IW'(NUM_INPUTS - 1)) ? '0 : last_idx + 1'b1;
      for (int i = 0; i < NUM_INPUTS; i++) begin
        if (grant[i])            pcnt[i] <= PW'(PULSE_WIDTH);
        else if (pcnt[i] != '0)  pcnt[i] <= pcnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    output_spikes = '0;
    for (int i = 0; i < NUM_INPUTS; i++) output_spikes[i] = (pcnt[i] != '0);
  end

  assign gamma_start = (gcnt == '0);

endmodule

// File: tb/tb_kwta_tie_break.sv
// Directed bench for kwta_tie_break: default, round-robin, K=1 and falling-edge instances.
module tb_kwta_tie_break;
  import kwta_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] spk;
  logic [7:0] spk_fall;

  logic [7:0] out_fix, out_rr, out_k1, out_fall;
  logic       gs_fix, gs_rr, gs_k1, gs_fall;
  logic [1:0] wc_fix, wc_rr, wc_fall;
  logic [0:0] wc_k1;

  int n_tests = 0;
  int n_fail  = 0;

  kwta_tie_break dut_fix (
    .clk(clk), .rst_n(rst_n), .input_spikes(spk),
    .output_spikes(out_fix), .gamma_start(gs_fix), .win_count(wc_fix));

  kwta_tie_break #(.TIE_MODE(TIE_RR)) dut_rr (
    .clk(clk), .rst_n(rst_n), .input_spikes(spk),
    .output_spikes(out_rr), .gamma_start(gs_rr), .win_count(wc_rr));

  kwta_tie_break #(.K(1)) dut_k1 (
    .clk(clk), .rst_n(rst_n), .input_spikes(spk),
    .output_spikes(out_k1), .gamma_start(gs_k1), .win_count(wc_k1));

  kwta_tie_break #(.EDGE_MODE(EDGE_FALLING)) dut_fall (
    .clk(clk), .rst_n(rst_n), .input_spikes(spk_fall),
    .output_spikes(out_fall), .gamma_start(gs_fall), .win_count(wc_fall));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After this returns, the next posedge samples with gcnt == 0.
  task automatic do_reset();
    rst_n    = 1'b0;
    spk      = 8'h00;
    spk_fall = 8'hFF;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    spk      = 8'h08;
    spk_fall = 8'hFF;
    repeat (3) tick();
    rst_n = 1'b1;
    n_tests++; if (out_fix !== 8'h00) begin n_fail++; $display("FAIL reset_out: got %h want 00", out_fix); end
    n_tests++; if (wc_fix !== 2'd0) begin n_fail++; $display("FAIL reset_wc: got %0d want 0", wc_fix); end
    n_tests++; if (gs_fix !== 1'b1) begin n_fail++; $display("FAIL reset_gamma_start: got %b want 1", gs_fix); end
    tick();
    n_tests++; if (out_fix !== 8'h08) begin n_fail++; $display("FAIL reset_first_edge: got %h want 08", out_fix); end
    n_tests++; if (gs_fix !== 1'b0) begin n_fail++; $display("FAIL reset_gs_after: got %b want 0", gs_fix); end
    repeat (2) tick();
    rst_n = 1'b0;
    tick();
    n_tests++; if (out_fix !== 8'h00) begin n_fail++; $display("FAIL reset_mid_pulse: got %h want 00", out_fix); end
    n_tests++; if (wc_fix !== 2'd0) begin n_fail++; $display("FAIL reset_mid_wc: got %0d want 0", wc_fix); end
  endtask

  task automatic test_ordered();
    logic [7:0] exp_out;
    logic [1:0] exp_wc;
    do_reset();
    for (int t = 1; t <= 14; t++) begin
      case (t)
        1: spk = spk | 8'h08;
        2: spk = spk | 8'h80;
        3: spk = spk | 8'h40;
        4: spk = spk | 8'h04;
        5: spk = spk | 8'h01;
        default: ;
      endcase
      tick();
      exp_out = 8'h00;
      if (t >= 1 && t <= 8)  exp_out = exp_out | 8'h08;
      if (t >= 2 && t <= 9)  exp_out = exp_out | 8'h80;
      if (t >= 3 && t <= 10) exp_out = exp_out | 8'h40;
      exp_wc = (t < 3) ? 2'(t) : 2'd3;
      n_tests++; if (out_fix !== exp_out) begin n_fail++; $display("FAIL ordered_out t=%0d: got %h want %h", t, out_fix, exp_out); end
      n_tests++; if (wc_fix !== exp_wc) begin n_fail++; $display("FAIL ordered_wc t=%0d: got %0d want %0d", t, wc_fix, exp_wc); end
    end
  endtask

  task automatic test_tie_fixed();
    do_reset();
    spk = 8'h20; tick();
    spk = spk | 8'h40; tick();
    spk = spk | 8'h14; tick();
    n_tests++; if (out_fix !== 8'h64) begin n_fail++; $display("FAIL tie_fixed_out: got %h want 64", out_fix); end
    n_tests++; if (wc_fix !== 2'd3) begin n_fail++; $display("FAIL tie_fixed_wc: got %0d want 3", wc_fix); end
    tick();
    n_tests++; if (out_fix !== 8'h64) begin n_fail++; $display("FAIL tie_fixed_loser: got %h want 64", out_fix); end
  endtask

  task automatic test_tie_rr();
    do_reset();
    spk = 8'h09; tick();
    n_tests++; if (out_rr !== 8'h09) begin n_fail++; $display("FAIL rr_first_out: got %h want 09", out_rr); end
    n_tests++; if (dut_rr.ptr !== 3'd4) begin n_fail++; $display("FAIL rr_ptr_first: got %0d want 4", dut_rr.ptr); end
    spk = spk | 8'h44; tick();
    n_tests++; if (out_rr !== 8'h49) begin n_fail++; $display("FAIL rr_tie_out: got %h want 49", out_rr); end
    n_tests++; if (wc_rr !== 2'd3) begin n_fail++; $display("FAIL rr_tie_wc: got %0d want 3", wc_rr); end
    n_tests++; if (dut_rr.ptr !== 3'd7) begin n_fail++; $display("FAIL rr_ptr_tie: got %0d want 7", dut_rr.ptr); end
    n_tests++; if (out_fix !== 8'h0D) begin n_fail++; $display("FAIL rr_fixed_rerun: got %h want 0d", out_fix); end
  endtask

  task automatic test_boundary();
    do_reset();
    repeat (15) tick();
    spk = 8'h02; tick();
    n_tests++; if (out_k1 !== 8'h02) begin n_fail++; $display("FAIL bnd_end_cycle_out: got %h want 02", out_k1); end
    n_tests++; if (wc_k1 !== 1'b1) begin n_fail++; $display("FAIL bnd_end_cycle_wc: got %0d want 1", wc_k1); end
    n_tests++; if (gs_k1 !== 1'b1) begin n_fail++; $display("FAIL bnd_gamma_start: got %b want 1", gs_k1); end
    spk = spk | 8'h04; tick();
    n_tests++; if (out_k1 !== 8'h06) begin n_fail++; $display("FAIL bnd_new_cycle_out: got %h want 06", out_k1); end
    n_tests++; if (wc_k1 !== 1'b1) begin n_fail++; $display("FAIL bnd_new_cycle_wc: got %0d want 1", wc_k1); end
    n_tests++; if (gs_k1 !== 1'b0) begin n_fail++; $display("FAIL bnd_gs_after: got %b want 0", gs_k1); end
    spk = spk | 8'h08; tick();
    n_tests++; if (out_k1 !== 8'h06) begin n_fail++; $display("FAIL bnd_full_ignored: got %h want 06", out_k1); end
    repeat (5) tick();
    n_tests++; if (out_k1 !== 8'h06) begin n_fail++; $display("FAIL bnd_pulse_persist: got %h want 06", out_k1); end
    tick();
    n_tests++; if (out_k1 !== 8'h04) begin n_fail++; $display("FAIL bnd_pulse_end1: got %h want 04", out_k1); end
    tick();
    n_tests++; if (out_k1 !== 8'h00) begin n_fail++; $display("FAIL bnd_pulse_end2: got %h want 00", out_k1); end
  endtask

  task automatic test_falling();
    do_reset();
    spk_fall = 8'hEF; tick();
    n_tests++; if (out_fall !== 8'h10) begin n_fail++; $display("FAIL fall_first: got %h want 10", out_fall); end
    spk_fall = spk_fall & 8'hDD; tick();
    n_tests++; if (out_fall !== 8'h32) begin n_fail++; $display("FAIL fall_tie: got %h want 32", out_fall); end
    n_tests++; if (wc_fall !== 2'd3) begin n_fail++; $display("FAIL fall_wc: got %0d want 3", wc_fall); end
    spk_fall = spk_fall & 8'hFE; tick();
    n_tests++; if (out_fall !== 8'h32) begin n_fail++; $display("FAIL fall_late_ignored: got %h want 32", out_fall); end
  endtask

  initial begin
    rst_n    = 1'b0;
    spk      = 8'h00;
    spk_fall = 8'hFF;
    test_reset();
    test_ordered();
    test_tie_fixed();
    test_tie_rr();
    test_boundary();
    test_falling();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kwta_tie_break.md
Name: kwta_tie_break

Overview:
- k-winner-take-all stage for the temporal neural column. Passes only the first K input spike edges in each gamma cycle, each as a fixed-width output pulse.
- Successor to the no-tie-break kWTA. Adds three things:
  - deterministic tie-breaking when simultaneous edges exceed the remaining slots, with fixed or round-robin priority;
  - selectable rising or falling spike encoding;
  - an internal gamma-cycle counter with status outputs.

Parameters:
- NUM_INPUTS, 8: number of spike lines.
- K, 3: maximum winners per gamma cycle (1..NUM_INPUTS).
- GAMMA_CYCLE_WIDTH, 16: clocks per gamma cycle (>=2).
- PULSE_WIDTH, 8: output pulse length in clocks (1..GAMMA_CYCLE_WIDTH).
- EDGE_MODE, EDGE_RISING: EDGE_RISING means spike = 0->1 and the idle level is 0. EDGE_FALLING means spike = 1->0 and the idle level is 1.
- TIE_MODE, TIE_FIXED: TIE_FIXED gives lowest index priority. TIE_RR gives rotating priority.

Ports:
- clk  in  1  single clock; all state is updated on the posedge.
- rst_n  in  1  synchronous, active-low reset.
- input_spikes  in  NUM_INPUTS  spike lines in the EDGE_MODE encoding.
- output_spikes  out  NUM_INPUTS  active-high winner pulses in both modes.
- gamma_start  out  1  high while gcnt==0.
- win_count  out  $clog2(K+1)  number of winners granted so far in the current gamma cycle.

Behaviour:
- **Reset** (rst_n==0 at posedge), also applied mid-operation:
  - gcnt=0, won=0, win_count=0, ptr=0;
  - all pulse counters 0, so output_spikes=0;
  - prev=idle level replicated across all lines.
  - First posedge after release samples with gcnt==0, so gamma_start=1.
- **Gamma counter:** gcnt runs 0..GAMMA_CYCLE_WIDTH-1 and wraps to 0. gamma_start=(gcnt==0), taken directly from the register.
- **Edge detect:** edge[i] = input_spikes[i] is at its active level AND prev[i] is at the idle level. prev<=input_spikes every cycle.
- **Cycle membership:** a sample taken while gcnt==0 belongs to the new cycle. It uses won_eff=0 and cnt_eff=0; otherwise won_eff=won and cnt_eff=win_count.
- **Grant computation:**
  - eligible = edge & ~won_eff;
  - rem = K - cnt_eff;
  - grant = first min(rem, popcount(eligible)) eligible bits in priority order.
  - TIE_FIXED order: index 0 upward.
  - TIE_RR order: ptr, ptr+1, ... mod NUM_INPUTS.
- **Registered update per posedge:**
  - won <= won_eff | grant;
  - win_count <= cnt_eff + popcount(grant), never exceeding K;
  - TIE_RR with grant!=0: ptr <= (highest-priority-order last granted index + 1) mod NUM_INPUTS.
  - ptr is unused in TIE_FIXED and stays 0.
- **Outputs:**
  - grant[i] loads pcnt[i]=PULSE_WIDTH; otherwise a nonzero pcnt[i] decrements. output_spikes[i] = (pcnt[i]!=0).
  - Latency: an edge sampled at posedge t gives output high for posedges t+1..t+PULSE_WIDTH.
  - Pulses are not truncated at the gamma boundary.
  - A re-grant during an active pulse reloads pcnt.
- **Boundary cases:**
  - An input held active across cycles produces no new edge.
  - Once K winners exist, later edges in the same cycle are ignored; they are not queued.
  - An edge at gcnt==GAMMA_CYCLE_WIDTH-1 counts in the ending cycle.
  - An edge at gcnt==0 counts in the new cycle.
  - A losing input that stays active never wins later in the cycle, because it produces no new edge.

Decomposition:
- kwta_pkg holds:
  - typedef enum edge_mode_e {EDGE_RISING, EDGE_FALLING};
  - typedef enum tie_mode_e {TIE_FIXED, TIE_RR};
  - a popcount function.
- Sub-module kwta_priority_sel:
  - combinational; takes req[N], start index and limit;
  - produces grant[N] and last_idx;
  - implemented as rotate, then thermometer-limited first-M select, then rotate back.
- kwta_tie_break holds all sequential state.

Test Plan:
All scenarios use the defaults unless stated otherwise.

1. Reset: hold rst_n=0 for 3 clocks with input_spikes[3]=1 -> output_spikes=0, win_count=0, gamma_start=1 after release. Asserting rst_n=0 mid-pulse clears output_spikes at the next posedge.
2. Ordered arrivals: edges on inputs 3, 7, 6, 2, 0 on successive clocks within one cycle -> only 3, 7, 6 pulse, each for exactly 8 clocks starting 1 clock after its edge. win_count reaches 3 and stays there; 2 and 0 never pulse.
3. Tie, TIE_FIXED: inputs 5 then 6 win; later 2 and 4 rise together -> only 2 pulses, win_count=3.
4. Tie, TIE_RR: cycle A, inputs 0 and 3 win, then 2 and 6 rise together with 1 slot left -> 6 wins and ptr=7. Rerun with TIE_FIXED -> 2 wins.
5. Boundary: an edge at gcnt=15 and another at gcnt=0 on a different input, with K=1 -> both win (separate cycles). Win state clears at gamma_start, and the gcnt=15 pulse persists the full 8 clocks.
6. EDGE_FALLING: inputs idle at 1; input 4 falls, then 1 and 5 fall together, then 0 falls -> output_spikes pulses high on 4, 1 and 5 only.
